instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 14 +
 rtl/instr_loader.sv | 104 ++++++++++
 2 files changed

// File: rtl/instr_loader_pkg.sv
// Shared processor definitions for the instruction loader.
// Holds the loader state encoding and the instruction word geometry.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } ldr_state_e;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles big-endian bytes into
// 32-bit words and writes them to instruction memory, holding the core.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_wr_en,
    output logic [31:0]       imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              core_hold,
    output logic              done
);

    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        byte_ready   = 1'b0;
        imem_wr_en   = 1'b0;
        imem_wr_addr = 32'h0;
        imem_wr_data = 32'h0;
        core_hold    = 1'b1;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                core_hold = 1'b0;
                if (start) begin
                    count_d    = word_count;
                    index_d    = '0;
                    byte_cnt_d = '0;
                    state_d    = (word_count == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    asm_d      = {asm_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                imem_wr_en   = 1'b1;
                imem_wr_data = asm_q;
                imem_wr_addr = BASE_ADDR
                             + 32'(index_q) * 32'(BYTES_PER_WORD);
                if (index_q == count_q - ONE) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + ONE;
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

endmodule
